// File: rtl/btn_mode_select.sv
// Debounced up/down buttons stepping a 2-bit speed mode for the downstream clock divider.
// Optional MODE_WRAP_EN: wrap 3->0 / 0->3 instead of saturating at the ends.
module btn_mode_select #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,  // >= 2
  parameter int CNT_W           = 20          // 2**CNT_W > DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] mode,
  output logic       mode_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the up channel, bit 1 the down channel.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       st;
  logic [1:0]       st_d;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       press;
  logic [1:0]       mode_next;

  assign raw = {btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      st     <= '0;
      st_d   <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      st_d <= st;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          st[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only accepted rising levels act; releases are ignored.
  assign press = st & ~st_d;

  always_comb begin
    mode_next = mode;
    if (press == 2'b01) begin
`ifdef MODE_WRAP_EN
      mode_next = mode + 2'd1;
`else
      if (mode != 2'd3) mode_next = mode + 2'd1;
`endif
    end else if (press == 2'b10) begin
`ifdef MODE_WRAP_EN
      mode_next = mode - 2'd1;
`else
      if (mode != 2'd0) mode_next = mode - 2'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode         <= 2'd0;
      mode_changed <= 1'b0;
    end else begin
      mode         <= mode_next;
      mode_changed <= (mode_next != mode);
    end
  end

endmodule
